// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with req/ack memory port, prefetch queue and branch redirect
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk1,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        branch_valid,
  input  logic [31:0] branch_target
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, DROP = 2'd2;
  logic [1:0] state, state_nx;
  logic [31:0] fetch_pc, hold_addr;
  logic [31:0] q_data [DEPTH];
  logic [31:0] q_pc [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count, count_nx;
  logic push, pop;
  assign mem_req    = state != IDLE;
  assign mem_addr   = state == DROP ? hold_addr : fetch_pc;
  assign inst_valid = count != '0;
  assign inst_out   = q_data[rd_ptr];
  assign inst_pc    = q_pc[rd_ptr];
  assign push       = state == REQ && mem_ack && !branch_valid;
  assign pop        = inst_valid && inst_ready && !branch_valid;
  assign count_nx   = branch_valid ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
  // A branch while a read is still outstanding must wait out that read in DROP
  assign state_nx = branch_valid ? ((mem_req && !mem_ack) ? DROP : REQ)
                  : state == IDLE ? (count != FULL ? REQ : IDLE)
                  : !mem_ack ? state
                  : state == DROP ? REQ
                  : (count_nx != FULL ? REQ : IDLE);
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      hold_addr <= RESET_PC;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else begin
      state    <= state_nx;
      count    <= count_nx;
      fetch_pc <= branch_valid ? (branch_target & ~32'd3) : push ? fetch_pc + 32'd4 : fetch_pc;
      rd_ptr   <= branch_valid ? '0 : rd_ptr + AW'(pop);
      wr_ptr   <= branch_valid ? '0 : wr_ptr + AW'(push);
      if (state == REQ) hold_addr <= fetch_pc;
      if (push) begin
        q_data[wr_ptr] <= mem_rdata;
        q_pc[wr_ptr]   <= fetch_pc;
      end
    end
  end
endmodule
